// File: rtl/rail_sequencer.sv
// Power-rail sequencer: enables rails in ascending order, disables them in descending
// order, with a shared down-counter for inter-rail delay and power-good timeout.
module rail_sequencer #(
  parameter int N_RAILS = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pwr_req,
  input  logic [CNT_W-1:0]   seq_delay,
  input  logic [CNT_W-1:0]   pg_timeout,
  input  logic [N_RAILS-1:0] pg,
  input  logic               fault_clr,
  output logic [N_RAILS-1:0] rail_en,
  output logic               pwr_ok,
  output logic               busy,
  output logic               fault,
  output logic [2:0]         fault_rail,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_DLY = 3'd1,
    UP_PG  = 3'd2,
    ON     = 3'd3,
    DN_DLY = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [2:0]         LAST_IDX = 3'(N_RAILS - 1);
  localparam logic [N_RAILS-1:0] ONE_HOT0 = N_RAILS'(1);

  state_t             state_reg;
  logic [N_RAILS-1:0] rail_en_reg;
  logic [2:0]         idx_reg;
  logic [2:0]         fault_rail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   d_reg;
  logic [CNT_W-1:0]   t_reg;
  logic               pwr_ok_reg;
  logic               fault_reg;

  logic [N_RAILS-1:0] idx_onehot;
  logic [N_RAILS-1:0] mon_mask;
  logic [N_RAILS-1:0] mon_bad;
  logic               mon_hit;
  logic [2:0]         mon_idx;
  logic               pg_cur;
  logic               count_zero;
  logic               to_fault;
  logic [2:0]         fault_idx;

  // The rail awaiting power-good in UP_PG is not yet "established", so it is
  // left to the timeout path rather than the monitor.
  always_comb begin
    idx_onehot = ONE_HOT0 << idx_reg;
    pg_cur     = |(pg & idx_onehot);
    count_zero = (count_reg == '0);
    mon_mask   = rail_en_reg & ~((state_reg == UP_PG) ? idx_onehot : '0);
    mon_bad    = mon_mask & ~pg;
    mon_hit    = (state_reg inside {UP_DLY, UP_PG, ON, DN_DLY}) && (|mon_bad);
    mon_idx    = '0;
    for (int j = N_RAILS - 1; j >= 0; j--) begin
      if (mon_bad[j]) mon_idx = 3'(j);
    end
    to_fault   = mon_hit || ((state_reg == UP_PG) && !pg_cur && count_zero);
    fault_idx  = mon_hit ? mon_idx : idx_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rail_en_reg    <= '0;
      idx_reg        <= '0;
      fault_rail_reg <= '0;
      count_reg      <= '0;
      d_reg          <= '0;
      t_reg          <= '0;
      pwr_ok_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else if (to_fault) begin
      state_reg      <= FAULT;
      rail_en_reg    <= '0;
      fault_reg      <= 1'b1;
      fault_rail_reg <= fault_idx;
      pwr_ok_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pwr_req) begin
            d_reg     <= seq_delay;
            t_reg     <= pg_timeout;
            idx_reg   <= '0;
            count_reg <= seq_delay;
            state_reg <= UP_DLY;
          end
        end
        UP_DLY: begin
          if (!pwr_req) begin
            count_reg <= d_reg;
            if (idx_reg == '0) begin
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg - 3'd1;
              state_reg <= DN_DLY;
            end
          end else if (!count_zero) begin
            count_reg <= count_reg - 1'b1;
          end else begin
            rail_en_reg <= rail_en_reg | idx_onehot;
            count_reg   <= t_reg;
            state_reg   <= UP_PG;
          end
        end
        UP_PG: begin
          if (!pwr_req) begin
            count_reg <= d_reg;
            state_reg <= DN_DLY;
          end else if (pg_cur) begin
            if (idx_reg == LAST_IDX) begin
              pwr_ok_reg <= 1'b1;
              state_reg  <= ON;
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              count_reg <= d_reg;
              state_reg <= UP_DLY;
            end
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        ON: begin
          if (!pwr_req) begin
            idx_reg    <= LAST_IDX;
            count_reg  <= d_reg;
            pwr_ok_reg <= 1'b0;
            state_reg  <= DN_DLY;
          end
        end
        DN_DLY: begin
          if (!count_zero) begin
            count_reg <= count_reg - 1'b1;
          end else begin
            rail_en_reg <= rail_en_reg & ~idx_onehot;
            if (idx_reg == '0) begin
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg - 3'd1;
              count_reg <= d_reg;
            end
          end
        end
        FAULT: begin
          if (fault_clr && !pwr_req) begin
            fault_reg      <= 1'b0;
            fault_rail_reg <= '0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          rail_en_reg <= '0;
        end
      endcase
    end
  end

  assign rail_en    = rail_en_reg;
  assign pwr_ok     = pwr_ok_reg;
  assign fault      = fault_reg;
  assign fault_rail = fault_rail_reg;
  assign state      = state_reg;
  assign count      = count_reg;
  assign busy       = (state_reg == UP_DLY) || (state_reg == UP_PG) || (state_reg == DN_DLY);

endmodule

// File: tb/tb_rail_sequencer.sv
// Directed bench for rail_sequencer: power-up/down, timeout, monitor faults, abort,
// async reset and the D=0 minimum spacing.
module tb_rail_sequencer;

  localparam int N_RAILS = 4;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               pwr_req;
  logic [CNT_W-1:0]   seq_delay;
  logic [CNT_W-1:0]   pg_timeout;
  logic [N_RAILS-1:0] pg;
  logic [N_RAILS-1:0] pg_kill;
  logic               fault_clr;
  logic [N_RAILS-1:0] rail_en;
  logic               pwr_ok;
  logic               busy;
  logic               fault;
  logic [2:0]         fault_rail;
  logic [2:0]         state;
  logic [CNT_W-1:0]   count;

  int vectors = 0;
  int miscompares = 0;

  rail_sequencer #(.N_RAILS(N_RAILS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwr_req    (pwr_req),
    .seq_delay  (seq_delay),
    .pg_timeout (pg_timeout),
    .pg         (pg),
    .fault_clr  (fault_clr),
    .rail_en    (rail_en),
    .pwr_ok     (pwr_ok),
    .busy       (busy),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Regulators modelled as ideal: power-good follows the enable, minus forced drops.
  assign pg = rail_en & ~pg_kill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_fault();
    pwr_req   = 1'b0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pwr_req    = 1'b0;
    seq_delay  = 32'd3;
    pg_timeout = 32'd5;
    pg_kill    = '0;
    fault_clr  = 1'b0;
    step(2);
    check("rst_state", 32'(state), 0);
    check("rst_rail_en", 32'(rail_en), 0);
    check("rst_count", count, 0);
    check("rst_pwr_ok", 32'(pwr_ok), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_fault_rail", 32'(fault_rail), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    step(1);

    // Clean power-up, accept at E0
    pwr_req = 1'b1;
    step(1);
    check("up_e0_state", 32'(state), 1);
    check("up_e0_count", count, 3);
    check("up_e0_busy", 32'(busy), 1);
    seq_delay = 32'd9;
    step(3);
    check("up_e3_rail_en", 32'(rail_en), 0);
    check("up_e3_count", count, 0);
    step(1);
    check("up_e4_rail_en", 32'(rail_en), 32'h1);
    check("up_e4_state", 32'(state), 2);
    check("up_e4_count", count, 5);
    step(5);
    check("up_e9_rail_en", 32'(rail_en), 32'h3);
    step(5);
    check("up_e14_rail_en", 32'(rail_en), 32'h7);
    step(5);
    check("up_e19_rail_en", 32'(rail_en), 32'hf);
    check("up_e19_pwr_ok", 32'(pwr_ok), 0);
    step(1);
    check("up_e20_pwr_ok", 32'(pwr_ok), 1);
    check("up_e20_state", 32'(state), 3);
    check("up_e20_busy", 32'(busy), 0);

    // Power-down from ON using the captured D=3
    pwr_req = 1'b0;
    step(1);
    check("dn_ed_state", 32'(state), 4);
    check("dn_ed_count", count, 3);
    check("dn_ed_pwr_ok", 32'(pwr_ok), 0);
    step(3);
    check("dn_ed3_rail_en", 32'(rail_en), 32'hf);
    step(1);
    check("dn_ed4_rail_en", 32'(rail_en), 32'h7);
    step(4);
    check("dn_ed8_rail_en", 32'(rail_en), 32'h3);
    step(4);
    check("dn_ed12_rail_en", 32'(rail_en), 32'h1);
    step(4);
    check("dn_ed16_rail_en", 32'(rail_en), 0);
    check("dn_ed16_state", 32'(state), 0);
    check("dn_ed16_fault", 32'(fault), 0);

    // Power-good timeout on rail 2
    seq_delay = 32'd3;
    pg_kill   = 4'b0100;
    pwr_req   = 1'b1;
    step(1);
    step(14);
    check("to_e14_rail_en", 32'(rail_en), 32'h7);
    check("to_e14_state", 32'(state), 2);
    step(5);
    check("to_e19_state", 32'(state), 2);
    check("to_e19_count", count, 0);
    step(1);
    check("to_e20_state", 32'(state), 5);
    check("to_e20_rail_en", 32'(rail_en), 0);
    check("to_e20_fault", 32'(fault), 1);
    check("to_e20_fault_rail", 32'(fault_rail), 2);
    pg_kill   = '0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("to_clr_req1_state", 32'(state), 5);
    check("to_clr_req1_fault", 32'(fault), 1);
    clear_fault();
    check("to_clr_state", 32'(state), 0);
    check("to_clr_fault", 32'(fault), 0);
    check("to_clr_fault_rail", 32'(fault_rail), 0);

    // Monitor fault in ON: single rail drop, then two simultaneous drops
    pwr_req = 1'b1;
    step(21);
    check("mon_on_state", 32'(state), 3);
    pg_kill = 4'b0010;
    step(1);
    pg_kill = '0;
    check("mon1_state", 32'(state), 5);
    check("mon1_rail_en", 32'(rail_en), 0);
    check("mon1_fault_rail", 32'(fault_rail), 1);
    clear_fault();
    pwr_req = 1'b1;
    step(21);
    check("mon2_on_state", 32'(state), 3);
    pg_kill = 4'b1010;
    step(1);
    pg_kill = '0;
    check("mon2_state", 32'(state), 5);
    check("mon2_fault_rail", 32'(fault_rail), 1);
    clear_fault();

    // Abort while waiting for rail 1 power-good
    pwr_req = 1'b1;
    step(10);
    check("ab_e9_rail_en", 32'(rail_en), 32'h3);
    check("ab_e9_state", 32'(state), 2);
    pwr_req = 1'b0;
    step(1);
    check("ab_ea_state", 32'(state), 4);
    check("ab_ea_count", count, 3);
    step(3);
    check("ab_ea3_rail_en", 32'(rail_en), 32'h3);
    step(1);
    check("ab_ea4_rail_en", 32'(rail_en), 32'h1);
    check("ab_ea4_state", 32'(state), 4);
    step(4);
    check("ab_ea8_rail_en", 32'(rail_en), 0);
    check("ab_ea8_state", 32'(state), 0);

    // Async reset between edges while in UP_DLY for rail 1
    pwr_req = 1'b1;
    step(7);
    check("ar_pre_state", 32'(state), 1);
    check("ar_pre_rail_en", 32'(rail_en), 32'h1);
    check("ar_pre_count", count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", 32'(state), 0);
    check("ar_rail_en", 32'(rail_en), 0);
    check("ar_count", count, 0);
    pwr_req = 1'b0;
    #1;
    reset = 1'b0;
    step(1);

    // D=0 rerun: two-cycle rail spacing
    seq_delay = 32'd0;
    pwr_req   = 1'b1;
    step(1);
    check("d0_e0_state", 32'(state), 1);
    check("d0_e0_count", count, 0);
    step(1);
    check("d0_e1_rail_en", 32'(rail_en), 32'h1);
    step(1);
    check("d0_e2_rail_en", 32'(rail_en), 32'h1);
    step(1);
    check("d0_e3_rail_en", 32'(rail_en), 32'h3);
    step(2);
    check("d0_e5_rail_en", 32'(rail_en), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rail_sequencer.md
# rail_sequencer

Power-rail sequencing controller for the PMIC. Enables up to `N_RAILS` regulator outputs in ascending order and disables them in descending order. Each step is spaced by a programmable down-counted delay, and each power-up step waits for the rail's power-good with a down-counted timeout. Sits between the top-level power request/fault logic and the regulator enable pins, and provides the single shared timebase counter for all rails.

## Interface
- `N_RAILS`, 4, number of sequenced rails (2..8).
- `CNT_W`, 32, width of the delay/timeout down-counter.
- `clk` input 1: system clock, all logic on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `pwr_req` input 1: level. 1 = power up and hold; 0 = power down.
- `seq_delay` input CNT_W: inter-rail delay D, in cycles; captured on power-up accept.
- `pg_timeout` input CNT_W: power-good timeout T, in cycles; captured on power-up accept.
- `pg` input N_RAILS: power-good per rail, synchronous to `clk`.
- `fault_clr` input 1: single-cycle pulse that clears a latched fault.
- `rail_en` output N_RAILS: registered regulator enables.
- `pwr_ok` output 1: registered; 1 only in state ON.
- `busy` output 1: 1 in UP_DLY, UP_PG and DN_DLY.
- `fault` output 1: registered; 1 in state FAULT.
- `fault_rail` output 3: index of the rail that caused the fault.
- `state` output 3: IDLE=0, UP_DLY=1, UP_PG=2, ON=3, DN_DLY=4, FAULT=5.
- `count` output CNT_W: current down-counter value (debug).

## Operation
- Reset values: state=IDLE, `rail_en`=0, `count`=0, `idx`=0, `pwr_ok`=0, `fault`=0, `fault_rail`=0. A reset mid-sequence drops all enables at once.
- **IDLE**
  - If `pwr_req`=1: capture D and T, set idx=0, count=D, go to UP_DLY.
- **UP_DLY**
  - If count≠0: decrement.
  - If count==0: set `rail_en[idx]`=1, count=T, go to UP_PG.
- **UP_PG**
  - If `pg[idx]`=1 and idx==N_RAILS-1: go to ON.
  - If `pg[idx]`=1 and idx<N_RAILS-1: idx+1, count=D, go to UP_DLY.
  - Else if count==0: go to FAULT with `fault_rail`=idx.
  - Else: decrement count.
- **ON**
  - If `pwr_req`=0: idx=N_RAILS-1, count=D, go to DN_DLY.
- **DN_DLY**
  - If count≠0: decrement.
  - If count==0: clear `rail_en[idx]`.
    - If idx==0: go to IDLE.
    - Else: idx-1, count=D.
- **FAULT**
  - `rail_en` is cleared on the entry edge, so all rails drop together.
  - Exit to IDLE only when `fault_clr`=1 and `pwr_req`=0 in the same cycle; `fault` and `fault_rail` clear on that edge.
  - `fault_clr` has no effect in any other state.
- **Power-good monitor** (UP_DLY, UP_PG, ON, DN_DLY): any already-enabled rail j with `pg[j]`=0 triggers FAULT with `fault_rail`=j.
  - If several rails drop together, the lowest index is reported.
  - In DN_DLY, rails at or above the one just disabled are not monitored.
- **Abort during power-up** (`pwr_req`=0 in UP_DLY or UP_PG), in priority order:
  1. UP_DLY with idx==0: go to IDLE.
  2. UP_DLY with idx>0: go to DN_DLY with idx-1.
  3. UP_PG: go to DN_DLY with idx.
  - In all abort cases count reloads to D.
- **Priorities:** reset > monitor fault > pg timeout > abort > normal transition.
- **Arithmetic:** count is unsigned and never decrements below 0. D=0 gives the minimum step of 1 cycle in the delay state. T=0 requires pg on the first UP_PG cycle.
- D and T inputs are ignored except at the IDLE→UP_DLY accept; the captured values are also used for power-down.

## Timing
- All outputs are registered except `busy`, which is decoded from the state register.
- Accept edge E0 (IDLE→UP_DLY): `rail_en[0]` rises after edge E0+D+1.
- With `pg` following `rail_en` combinationally, consecutive rail enables are D+2 cycles apart.
- `pwr_ok` rises 1 edge after the last rail's pg is sampled.
- Timeout: with `pg` held low, FAULT is entered at edge E_en+T+1, where E_en is the edge that raised the enable.
- Power-down: the first enable drops D+1 edges after `pwr_req`=0 is sampled in ON; subsequent rails drop every D+1 edges.

## Test plan
All scenarios use N_RAILS=4, D=3, T=5 unless stated.

- **Clean power-up** (`pg` = `rail_en`, `pwr_req` raised, accepted at E0) → `rail_en` bits rise after E4, E9, E14, E19; `pwr_ok`=1 after E20; `busy` low after E20.
- **Power-down from ON** (`pwr_req`=0 sampled at Ed) → `rail_en[3..0]` fall after Ed+4, Ed+8, Ed+12, Ed+16; state=IDLE after Ed+16; `fault` stays 0.
- **Power-good timeout** (`pg[2]` held 0) → FAULT 6 edges after `rail_en[2]` rises; `rail_en`=0, `fault`=1, `fault_rail`=2. A `fault_clr` pulse with `pwr_req`=1 is ignored; with `pwr_req`=0 it returns to IDLE.
- **Monitor fault in ON** (`pg[1]` deasserted for one cycle) → FAULT on the next edge, all enables 0, `fault_rail`=1. With `pg[1]` and `pg[3]` dropping simultaneously, `fault_rail`=1.
- **Abort in UP_PG of rail 1** (`pwr_req`=0) → DN_DLY with idx=1, `rail_en[1]` off 4 edges later, then `rail_en[0]` off 4 edges after that, then IDLE.
- **Async reset mid-sequence** (`reset` pulsed between clock edges while in UP_DLY) → `rail_en`=0, state=0 and `count`=0 immediately. A D=0 rerun shows rail spacing of 2 cycles.
